stream_fifo: RTL

Parametrised synchronous FIFO, the successor to the team's single-pointer buffer. It uses a valid/ready handshake on both sides and first-word-fall-through reads, so the full 2**DEPTH_LOG entries are usable. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, sticky error flags, an optional legacy edge-triggered read mode, and a debug probe port. It sits between AXI-side bridges and compute blocks as the standard elastic buffer.

---
 rtl/stream_fifo.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Parametrised synchronous elastic buffer with valid/ready handshakes on both
// sides and first-word-fall-through reads, so all 2**DEPTH_LOG entries are
// usable. Occupancy is tracked in a dedicated counter; full/empty and the
// almost thresholds are all derived from that counter.
//
// Ports
//   clk           clock, rising edge
//   xrst          asynchronous active-low reset
//   clr           synchronous flush (pointers, count, sticky flags)
//   in_valid      producer has a word
//   in_ready      FIFO can accept a word (not full)
//   in_data       write data
//   out_valid     head word available (not empty)
//   out_ready     consumer takes the head word (level, or rising edge when
//                 RD_EDGE=1)
//   out_data      head word, combinational from storage at the read pointer
//   count         occupancy 0..DEPTH
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   overflow      sticky: in_valid seen while full
//   underflow     sticky: read request seen while empty
//   probe_addr    debug read address (raw memory index)
//   probe_data    memory word at probe_addr, no side effects
// -----------------------------------------------------------------------------
module stream_fifo #(
    parameter int DWIDTH    = 32,
    parameter int DEPTH_LOG = 4,
    parameter int AFULL_TH  = (2 ** DEPTH_LOG) - 2,
    parameter int AEMPTY_TH = 2,
    parameter int RD_EDGE   = 0
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DWIDTH-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DWIDTH-1:0]    out_data,
    output logic [DEPTH_LOG:0]   count,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    input  logic [DEPTH_LOG-1:0] probe_addr,
    output logic [DWIDTH-1:0]    probe_data
);

    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] LP_DEPTH    = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] LP_AFULL_TH = (DEPTH_LOG + 1)'(AFULL_TH);
    localparam logic [DEPTH_LOG:0] LP_AEMPT_TH = (DEPTH_LOG + 1)'(AEMPTY_TH);
    localparam logic               LP_LEVEL    = (RD_EDGE == 0);

    // Storage is never reset; it starts at zero in simulation only.
    logic [DWIDTH-1:0]    r_mem [DEPTH] = '{default: '0};

    logic [DEPTH_LOG-1:0] r_wptr;
    logic [DEPTH_LOG-1:0] r_rptr;
    logic [DEPTH_LOG:0]   r_count;
    logic                 r_out_ready_q;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_rd_req;
    logic                 w_push;
    logic                 w_pop;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);

    // In legacy mode only the rising edge of out_ready counts as a request.
    assign w_rd_req = out_ready & (LP_LEVEL | ~r_out_ready_q);

    // A flush cycle swallows any transfer presented with it.
    assign w_push = in_valid & ~w_full & ~clr;
    assign w_pop  = w_rd_req & ~w_empty & ~clr;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_out_ready_q <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (clr) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_out_ready_q <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_out_ready_q <= out_ready;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    assign in_ready     = ~w_full;
    assign out_valid    = ~w_empty;
    assign out_data     = r_mem[r_rptr];
    assign count        = r_count;
    assign almost_full  = (r_count >= LP_AFULL_TH);
    assign almost_empty = (r_count <= LP_AEMPT_TH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign probe_data   = r_mem[probe_addr];

endmodule
